univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: register width in bits (>= 2).
REQ-002 The block SHALL have parameter AMTW, default 3: width of the shift-amount input.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port ploadn, input, 1 bit: active-low parallel load.
REQ-006 The block SHALL have port datain, input, WIDTH bits: parallel load data.
REQ-007 The block SHALL have port start, input, 1 bit: request a multi-step operation.
REQ-008 The block SHALL have port mode, input, 2 bits: 00 rotate, 01 logical shift, 10 arithmetic shift, 11 serial shift.
REQ-009 The block SHALL have port rright, input, 1 bit: direction, 1 = right (toward bit 0), 0 = left.
REQ-010 The block SHALL have port amt, input, AMTW bits: number of single-bit steps to perform.
REQ-011 The block SHALL have port sin, input, 1 bit: serial fill bit for mode 11.
REQ-012 The block SHALL have port qout, output, WIDTH bits: register contents.
REQ-013 The block SHALL have port sout, output, 1 bit: bit that left the register on the most recent step.
REQ-014 The block SHALL have port busy, output, 1 bit: high while steps are executing.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-016 The block SHALL implement FSM states IDLE, SHIFT and DONE; busy = (state == SHIFT); done = (state == DONE).
REQ-017 Priority per edge SHALL be: reset > ploadn = 0 > FSM activity.
REQ-018 ploadn = 0 SHALL load qout <= datain, force state to IDLE and leave sout unchanged, in any state; an in-flight operation is aborted and no done pulse is produced.
REQ-019 In IDLE, start = 1 with ploadn = 1 SHALL latch mode, rright and amt; the next state is SHIFT if amt != 0, otherwise DONE.
REQ-020 start SHALL be ignored in SHIFT and DONE; mode, rright and amt changes after acceptance SHALL have no effect.
REQ-021 Each SHIFT cycle SHALL perform exactly one step on qout and decrement the step counter.
REQ-022 On the step with counter == 1 the FSM SHALL go to DONE; DONE SHALL return to IDLE after one cycle.
REQ-023 Latency: start accepted at edge t with amt = N > 0 SHALL give steps at edges t+1..t+N, busy high for N cycles, and done high for the one cycle after edge t+N.
REQ-024 amt = 0 SHALL produce done in the cycle after acceptance, with qout and sout unchanged.
REQ-025 Rotate SHALL move the exiting bit into the vacated end (right: bit 0 -> bit WIDTH-1; left: bit WIDTH-1 -> bit 0).
REQ-026 Logical shift SHALL fill the vacated bit with 0.
REQ-027 Arithmetic shift right SHALL fill with qout[WIDTH-1]; arithmetic shift left SHALL equal logical shift left.
REQ-028 Serial shift SHALL fill the vacated bit with sin sampled at that step's edge.
REQ-029 sout SHALL be updated on every step with the exiting bit (right: old bit 0; left: old bit WIDTH-1) and SHALL hold between steps.
REQ-030 In IDLE with start = 0 and ploadn = 1, qout SHALL hold.

Reset
REQ-031 reset = 1 at an edge SHALL set qout = 0, sout = 0, busy = 0, done = 0, state = IDLE and step counter = 0, from any state including mid-operation.
REQ-032 start and ploadn asserted with reset SHALL be ignored.

Verification (WIDTH = 8, AMTW = 3)
REQ-033 The bench SHALL cover: load 8'b1000_0000, mode 00, rright 0, amt 1 -> qout 8'b0000_0001, sout 1, done one cycle after the step.
REQ-034 The bench SHALL cover: load 8'b1000_0001, mode 00, rright 1, amt 3 -> qout 8'b0011_0000 after 3 cycles, busy high exactly 3 cycles.
REQ-035 The bench SHALL cover: load 8'b1001_0000, mode 10, rright 1, amt 2 -> qout 8'b1110_0100, sout 0; mode 01, same operation -> 8'b0010_0100.
REQ-036 The bench SHALL cover: load 8'hA5, mode 11, rright 0, amt 4, sin = 1,0,1,1 on successive steps -> qout 8'h5B.
REQ-037 The bench SHALL cover: start amt 7, then ploadn = 0 with datain 8'h3C on the third SHIFT cycle -> qout 8'h3C, busy 0 next cycle, no done pulse.
REQ-038 The bench SHALL cover: reset during SHIFT -> all outputs 0 next cycle; start with amt 0 in IDLE -> done one cycle later, qout unchanged.

Source files
------------

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with a multi-step operation sequencer.
//
// A parallel load (ploadn low) overrides everything except reset. In IDLE, a start
// request latches mode/direction/amount. The FSM then performs one single-bit step
// per cycle in SHIFT. After the last step it spends one cycle in DONE.
//
// Ports:
//   clk     - clock, all state changes on rising edge
//   reset   - synchronous active-high reset
//   ploadn  - active-low parallel load of datain (aborts any operation)
//   datain  - parallel load data [WIDTH]
//   start   - request an operation (only honoured in IDLE)
//   mode    - 00 rotate, 01 logical shift, 10 arithmetic shift, 11 serial shift
//   rright  - direction, 1 = right (toward bit 0), 0 = left
//   amt     - number of single-bit steps [AMTW]
//   sin     - serial fill bit for mode 11
//   qout    - register contents [WIDTH]
//   sout    - bit that left the register on the most recent step
//   busy    - high while steps are executing
//   done    - one-cycle completion pulse

module univ_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMTW  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ploadn,
    input  logic [WIDTH-1:0] datain,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             rright,
    input  logic [AMTW-1:0]  amt,
    input  logic             sin,
    output logic [WIDTH-1:0] qout,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              sout_q, sout_d;
    logic [AMTW-1:0]   cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic              dir_q, dir_d;

    logic              fill;
    logic [WIDTH-1:0]  step_val;
    logic              step_out;

    // Single-bit step using the operation parameters latched at acceptance.
    always_comb begin
        fill = 1'b0;
        unique case (mode_q)
            2'b00:   fill = dir_q ? q_q[0] : q_q[WIDTH-1];
            2'b01:   fill = 1'b0;
            2'b10:   fill = dir_q ? q_q[WIDTH-1] : 1'b0;  // left arithmetic == logical
            2'b11:   fill = sin;
            default: fill = 1'b0;
        endcase

        if (dir_q) begin
            step_val = {fill, q_q[WIDTH-1:1]};
            step_out = q_q[0];
        end else begin
            step_val = {q_q[WIDTH-2:0], fill};
            step_out = q_q[WIDTH-1];
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        sout_d  = sout_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dir_d   = dir_q;

        if (!ploadn) begin
            // Load wins over the sequencer; an in-flight operation is dropped silently.
            q_d     = datain;
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mode_d  = mode;
                        dir_d   = rright;
                        cnt_d   = amt;
                        state_d = (amt != '0) ? StShift : StDone;
                    end
                end
                StShift: begin
                    q_d    = step_val;
                    sout_d = step_out;
                    cnt_d  = cnt_q - AMTW'(1);
                    if (cnt_q == AMTW'(1)) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            q_q     <= '0;
            sout_q  <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
        end
    end

    assign qout = q_q;
    assign sout = sout_q;
    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH = 8, AMTW = 3).
// Expected results are queued when an operation is started and compared when
// the DUT raises done.

module tb_univ_shift_reg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned AMTW  = 3;

    logic             clk;
    logic             reset;
    logic             ploadn;
    logic [WIDTH-1:0] datain;
    logic             start;
    logic [1:0]       mode;
    logic             rright;
    logic [AMTW-1:0]  amt;
    logic             sin;
    logic [WIDTH-1:0] qout;
    logic             sout;
    logic             busy;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [7:0] q;
        logic       so;
        logic [7:0] steps;
    } exp_t;

    exp_t  sb_q[$];
    string sb_tag[$];

    univ_shift_reg #(
        .WIDTH (WIDTH),
        .AMTW  (AMTW)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .ploadn (ploadn),
        .datain (datain),
        .start  (start),
        .mode   (mode),
        .rright (rright),
        .amt    (amt),
        .sin    (sin),
        .qout   (qout),
        .sout   (sout),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_tests++;
        if (obs !== exp_val) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] d);
        ploadn = 1'b0;
        datain = d;
        tick();
        ploadn = 1'b1;
    endtask

    // Reference single step, written directly from the mode definitions.
    task automatic model_step(input logic [7:0] q, input logic [1:0] m, input logic dir,
                              input logic s, output logic [7:0] nq, output logic out);
        logic f;
        out = dir ? q[0] : q[7];
        case (m)
            2'b00:   f = out;
            2'b01:   f = 1'b0;
            2'b10:   f = dir ? q[7] : 1'b0;
            default: f = s;
        endcase
        nq = dir ? {f, q[7:1]} : {q[6:0], f};
    endtask

    // Start an operation, queue its expectation, then follow it to done.
    // Parameter inputs are scrambled after acceptance; they must have no effect.
    task automatic run_op(input string tag, input logic [1:0] m, input logic dir,
                          input logic [2:0] n, input logic [7:0] sin_seq,
                          input logic [7:0] exp_q, input logic exp_so);
        exp_t e;
        int   busy_cnt;
        int   done_at;
        bit   got;
        e.q     = exp_q;
        e.so    = exp_so;
        e.steps = 8'(n);
        sb_q.push_back(e);
        sb_tag.push_back(tag);

        mode   = m;
        rright = dir;
        amt    = n;
        start  = 1'b1;
        tick();
        start  = 1'b1;  // must be ignored while not in IDLE
        mode   = ~m;
        rright = ~dir;
        amt    = ~n;

        busy_cnt = 0;
        done_at  = -1;
        got      = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                got     = 1'b1;
                done_at = i;
            end else begin
                sin = sin_seq[i % 8];
                tick();
            end
        end
        start = 1'b0;

        if (!got) begin
            check({tag, " timeout"}, 32'd0, 32'd1);
            void'(sb_q.pop_front());
            void'(sb_tag.pop_front());
        end else begin
            exp_t  x;
            string t;
            x = sb_q.pop_front();
            t = sb_tag.pop_front();
            check({t, " qout"}, 32'(qout), 32'(x.q));
            check({t, " sout"}, 32'(sout), 32'(x.so));
            check({t, " busy cycles"}, 32'(busy_cnt), 32'(x.steps));
            check({t, " done latency"}, 32'(done_at), 32'(x.steps));
            tick();
            check({t, " done width"}, 32'(done), 32'd0);
            check({t, " idle after"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] mq;
        logic       mo;
        logic [7:0] d;
        logic [1:0] m;
        logic       dr;
        logic [2:0] n;
        logic [7:0] sq;
        bit         seen_done;

        reset  = 1'b1;
        ploadn = 1'b1;
        datain = '0;
        start  = 1'b0;
        mode   = 2'b00;
        rright = 1'b0;
        amt    = '0;
        sin    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("reset qout", 32'(qout), 32'd0);
        check("reset sout", 32'(sout), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);

        // Idle hold
        load(8'h5A);
        tick();
        tick();
        check("idle hold", 32'(qout), 32'h5A);

        load(8'b1000_0000);
        run_op("rotl1", 2'b00, 1'b0, 3'd1, 8'h00, 8'b0000_0001, 1'b1);

        load(8'b1000_0001);
        run_op("rotr3", 2'b00, 1'b1, 3'd3, 8'h00, 8'b0011_0000, 1'b0);

        load(8'b1001_0000);
        run_op("asr2", 2'b10, 1'b1, 3'd2, 8'hFF, 8'b1110_0100, 1'b0);
        load(8'b1001_0000);
        run_op("lsr2", 2'b01, 1'b1, 3'd2, 8'hFF, 8'b0010_0100, 1'b0);

        load(8'hA5);
        run_op("ser4", 2'b11, 1'b0, 3'd4, 8'b0000_1101, 8'h5B, 1'b0);

        // amt 0: qout and sout untouched (sout is 0 from the previous op)
        run_op("amt0", 2'b00, 1'b1, 3'd0, 8'h00, 8'h5B, 1'b0);

        // Abort by parallel load on the third SHIFT cycle
        load(8'hC0);
        mode   = 2'b00;
        rright = 1'b0;
        amt    = 3'd7;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort mid qout", 32'(qout), 32'h03);
        check("abort mid busy", 32'(busy), 32'd1);
        ploadn = 1'b0;
        datain = 8'h3C;
        tick();
        ploadn = 1'b1;
        check("abort qout", 32'(qout), 32'h3C);
        check("abort busy", 32'(busy), 32'd0);
        check("abort sout", 32'(sout), 32'd1);
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) seen_done = 1'b1;
            tick();
        end
        check("abort no done", 32'(seen_done), 32'd0);
        check("abort hold", 32'(qout), 32'h3C);

        // Reset during SHIFT, with start and ploadn asserted alongside it
        load(8'hFF);
        mode   = 2'b01;
        rright = 1'b1;
        amt    = 3'd6;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre-reset busy", 32'(busy), 32'd1);
        reset  = 1'b1;
        ploadn = 1'b0;
        datain = 8'hAA;
        start  = 1'b1;
        tick();
        reset  = 1'b0;
        ploadn = 1'b1;
        start  = 1'b0;
        check("rst qout", 32'(qout), 32'd0);
        check("rst sout", 32'(sout), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        tick();
        check("rst start ignored busy", 32'(busy), 32'd0);
        check("rst start ignored done", 32'(done), 32'd0);

        // Randomised operations against the reference step
        for (int k = 0; k < 8; k++) begin
            d  = 8'($urandom);
            m  = 2'($urandom_range(0, 3));
            dr = 1'($urandom_range(0, 1));
            n  = 3'($urandom_range(1, 7));
            sq = 8'($urandom);
            mq = d;
            mo = 1'b0;
            for (int s = 0; s < int'(n); s++) begin
                model_step(mq, m, dr, sq[s], mq, mo);
            end
            load(d);
            run_op($sformatf("rand%0d", k), m, dr, n, sq, mq, mo);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
